wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master Wishbone arbiter sharing one memory slave between instruction fetch (IF) and load/store unit (LSU).
//  Sits between the core's IF/LSU wishbone_if masters and the single memory wishbone_if slave.
//  Grants whole bus cycles (cycle high to cycle low). LSU has priority. A starvation counter guarantees IF progress.
// PARAMETERS
//  MAX_LSU_BURST   4        consecutive LSU grants allowed while IF waits; next arbitration goes to IF
//  TIMEOUT_CYCLES  255      (WB_ARB_TIMEOUT_EN only) cycles a granted transaction may wait for ack
// PORTS
//  clk         in   1    clock
//  reset       in   1    one clock; reset is asynchronous and active-low
//  if_bus      slave  wishbone_if   from instruction-fetch master
//  lsu_bus     slave  wishbone_if   from load_store_unit master
//  mem_bus     master wishbone_if   to memory slave
//  o_grant     out  2    {lsu,if} one-hot current grant, 2'b00 when idle
//  o_timeout   out  1    1-cycle pulse on watchdog abort (tied 0 without WB_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, o_grant=00, starve_cnt=0, o_timeout=0, wd_cnt=0.
//   All mem_bus strobe/cycle/write_enable=0, address/data_in=0, select=0. No ack to either master.
//  States: IDLE, GRANT_IF, GRANT_LSU.
//   IDLE: sample the cycle inputs from both masters.
//     LSU only -> GRANT_LSU.
//     IF only -> GRANT_IF.
//     Both high and starve_cnt<MAX_LSU_BURST -> GRANT_LSU.
//     Both high and starve_cnt==MAX_LSU_BURST -> GRANT_IF.
//     Neither -> stay IDLE.
//   GRANT_x: stay while granted master's cycle==1. On cycle==0 -> IDLE at next edge.
//     No direct GRANT_IF<->GRANT_LSU transition: every switch costs one IDLE cycle.
//  Arbitration latency: master raises cycle at edge N; o_grant set at edge N+1; slave sees request from N+1.
//  Muxing (combinational from registered grant):
//   - mem_bus strobe/cycle/write_enable/address/select/data_in = granted master's; all 0 in IDLE.
//   - Slave ack/data_out routed only to granted master. Non-granted master sees ack=0, data_out=0.
//   - A slave ack in IDLE is discarded.
//  starve_cnt (width clog2(MAX_LSU_BURST+1)):
//   - +1 on each IDLE->GRANT_LSU taken while IF cycle==1, saturating at MAX_LSU_BURST.
//   - Cleared on IDLE->GRANT_IF.
//   - Unchanged otherwise.
//  A master dropping cycle without ack aborts its transaction; the arbiter returns to IDLE normally.
//  Reset asserted mid-transaction: outputs drop immediately (async). The in-flight transaction is lost and not acked.
//  Master strobe/cycle changes of the non-granted master never reach mem_bus.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - wd_cnt clears on entry to GRANT_x and counts each granted cycle with no slave ack.
//   - When wd_cnt==TIMEOUT_CYCLES-1 without ack: for one cycle assert ack to the granted master with data_out=32'hDEAD_BEEF.
//     In the same cycle force mem_bus cycle/strobe=0 and pulse o_timeout=1.
//     Then next state is IDLE regardless of the master's cycle.
//   - A real ack in the same cycle wins: normal completion, no timeout.
//  Not defined: no watchdog, o_timeout tied 0, a hung slave stalls the granted master indefinitely.
// TESTING
//  1. Reset low 3 cycles with both cycle inputs 1 -> mem_bus cycle=0, o_grant=00, no acks. Release -> LSU granted one cycle later.
//  2. IF read addr 0x100, slave acks data 0x12345678 after 2 cycles -> IF data_out=0x12345678 with ack. LSU ack stays 0. Return to IDLE.
//  3. Both request continuously, MAX_LSU_BURST=4 -> grant order LSU,LSU,LSU,LSU,IF,LSU... with one IDLE cycle between grants.
//  4. LSU byte write addr 0x203, select 4'b1000, data 0xAB000000 while IF waits -> mem_bus carries exactly LSU fields. IF sees no ack.
//  5. Async reset during GRANT_LSU before ack -> mem_bus cycle drops same cycle. After release, state IDLE and starve_cnt=0.
//  6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks IF -> ack+0xDEADBEEF on cycle 8, o_timeout one pulse, IDLE next.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone classic bus bundle used for the IF, LSU and memory ports of wb_bus_arbiter.
interface wishbone_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = DATA_W / 8;

   logic              cycle;
   logic              strobe;
   logic              write_enable;
   logic [ADDR_W-1:0] address;
   logic [SEL_W-1:0]  select;
   logic [DATA_W-1:0] data_in;
   logic              ack;
   logic [DATA_W-1:0] data_out;

   modport master (
      output cycle, strobe, write_enable, address, select, data_in,
      input  ack, data_out
   );

   modport slave (
      input  cycle, strobe, write_enable, address, select, data_in,
      output ack, data_out
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: LSU priority with IF starvation guard, whole-cycle grants.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
   parameter int unsigned MAX_LSU_BURST  = 4
`ifdef WB_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic        clk,
   input  logic        reset,
   wishbone_if.slave   if_bus,
   wishbone_if.slave   lsu_bus,
   wishbone_if.master  mem_bus,
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam int unsigned SC_W = (MAX_LSU_BURST > 0) ? $clog2(MAX_LSU_BURST + 1) : 1;

   // Encoding doubles as the {lsu,if} one-hot grant.
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      GRANT_IF  = 2'b01,
      GRANT_LSU = 2'b10
   } state_t;

   state_t          state, state_nxt;
   logic [SC_W-1:0] starve_cnt, starve_nxt;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned WD_W         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   logic [WD_W-1:0] wd_cnt, wd_nxt;
   logic            abort_c;
`endif

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
`ifdef WB_ARB_TIMEOUT_EN
         wd_cnt     <= '0;
`endif
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
`ifdef WB_ARB_TIMEOUT_EN
         wd_cnt     <= wd_nxt;
`endif
      end
   end

   // Arbitration, starvation accounting and watchdog.
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
`ifdef WB_ARB_TIMEOUT_EN
      wd_nxt     = wd_cnt;
      abort_c    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (lsu_bus.cycle && (!if_bus.cycle || (starve_cnt < SC_W'(MAX_LSU_BURST)))) begin
               state_nxt = GRANT_LSU;
               if (if_bus.cycle && (starve_cnt < SC_W'(MAX_LSU_BURST))) begin
                  starve_nxt = starve_cnt + SC_W'(1);
               end
            end else if (if_bus.cycle) begin
               state_nxt  = GRANT_IF;
               starve_nxt = '0;
            end
         end
         GRANT_IF: begin
            if (!if_bus.cycle) state_nxt = IDLE;
         end
         GRANT_LSU: begin
            if (!lsu_bus.cycle) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      // Each transaction gets its own window; a real ack beats the abort.
      if (state == IDLE) begin
         wd_nxt = '0;
      end else if (mem_bus.ack) begin
         wd_nxt = '0;
      end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
         abort_c   = 1'b1;
         state_nxt = IDLE;
         wd_nxt    = '0;
      end else begin
         wd_nxt = wd_cnt + WD_W'(1);
      end
`endif
   end

   // Bus steering from the registered grant.
   always_comb begin
      mem_bus.cycle        = 1'b0;
      mem_bus.strobe       = 1'b0;
      mem_bus.write_enable = 1'b0;
      mem_bus.address      = '0;
      mem_bus.select       = '0;
      mem_bus.data_in      = '0;
      if_bus.ack           = 1'b0;
      if_bus.data_out      = '0;
      lsu_bus.ack          = 1'b0;
      lsu_bus.data_out     = '0;
      unique case (state)
         GRANT_IF: begin
            mem_bus.cycle        = if_bus.cycle;
            mem_bus.strobe       = if_bus.strobe;
            mem_bus.write_enable = if_bus.write_enable;
            mem_bus.address      = if_bus.address;
            mem_bus.select       = if_bus.select;
            mem_bus.data_in      = if_bus.data_in;
            if_bus.ack           = mem_bus.ack;
            if_bus.data_out      = mem_bus.data_out;
         end
         GRANT_LSU: begin
            mem_bus.cycle        = lsu_bus.cycle;
            mem_bus.strobe       = lsu_bus.strobe;
            mem_bus.write_enable = lsu_bus.write_enable;
            mem_bus.address      = lsu_bus.address;
            mem_bus.select       = lsu_bus.select;
            mem_bus.data_in      = lsu_bus.data_in;
            lsu_bus.ack          = mem_bus.ack;
            lsu_bus.data_out     = mem_bus.data_out;
         end
         default: ;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      if (abort_c) begin
         mem_bus.cycle  = 1'b0;
         mem_bus.strobe = 1'b0;
         if (state == GRANT_IF) begin
            if_bus.ack      = 1'b1;
            if_bus.data_out = TIMEOUT_DATA;
         end else begin
            lsu_bus.ack      = 1'b1;
            lsu_bus.data_out = TIMEOUT_DATA;
         end
      end
`endif
   end

   assign o_grant = state;

`ifdef WB_ARB_TIMEOUT_EN
   assign o_timeout = abort_c;
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomized scoreboard bench for wb_bus_arbiter: grant-rule model, field/route checks, directed corners.
module tb_wb_bus_arbiter;
   localparam int unsigned MAX_BURST = 4;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned TO_CYCLES = 8;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] grant;
   logic       timeout;

   wishbone_if if_bus();
   wishbone_if lsu_bus();
   wishbone_if mem_bus();

`ifdef WB_ARB_TIMEOUT_EN
   wb_bus_arbiter #(.MAX_LSU_BURST(MAX_BURST), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
`else
   wb_bus_arbiter #(.MAX_LSU_BURST(MAX_BURST)) dut (
`endif
      .clk(clk), .reset(reset), .if_bus(if_bus), .lsu_bus(lsu_bus), .mem_bus(mem_bus),
      .o_grant(grant), .o_timeout(timeout));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t       if_q[$];
   txn_t       lsu_q[$];
   logic [1:0] grant_log[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   bit         mon_en = 0;
   bit         slv_hang = 0;
   int         slv_fixed = -1;
   int         slv_cnt = 0;
   int         slv_target = 0;
   logic       req_if_s = 0;
   logic       req_lsu_s = 0;
   logic [1:0] m_grant = 2'b00;
   int         m_streak = 0;
   logic [1:0] prev_obs = 2'b00;
   logic [31:0] rd_a, rd_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'h100) return 32'h1234_5678;
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   task automatic drive(input bit who, input logic cyc, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      if (who) begin
         lsu_bus.cycle = cyc; lsu_bus.strobe = cyc; lsu_bus.write_enable = we;
         lsu_bus.address = a; lsu_bus.select = s; lsu_bus.data_in = d;
      end else begin
         if_bus.cycle = cyc; if_bus.strobe = cyc; if_bus.write_enable = we;
         if_bus.address = a; if_bus.select = s; if_bus.data_in = d;
      end
   endtask

   // One complete bus cycle from a master; expected response queued at issue time.
   task automatic do_txn(input bit who, input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd);
      txn_t t;
      bit   got;
      t.we = we; t.addr = a; t.sel = s; t.wdata = d; t.rdata = rd_model(a);
      rd = '0;
      got = 0;
      @(negedge clk); #1;
      if (who) lsu_q.push_back(t); else if_q.push_back(t);
      drive(who, 1'b1, we, a, s, d);
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk); #1;
         if (who ? lsu_bus.ack : if_bus.ack) begin
            got = 1;
            rd = who ? lsu_bus.data_out : if_bus.data_out;
         end
      end
      if (!got) begin
         check(who ? "lsu_ack_wait" : "if_ack_wait", 64'd0, 64'd1);
         if (who) void'(lsu_q.pop_back()); else void'(if_q.pop_back());
      end
      drive(who, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic rand_master(input bit who, input int n);
      logic [31:0] rd;
      for (int i = 0; i < n; i++) begin
         do_txn(who, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), $urandom, rd);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   // Memory slave: acks after a per-transaction wait, read data from rd_model.
   initial begin
      mem_bus.ack = 1'b0;
      mem_bus.data_out = '0;
      forever begin
         @(posedge clk); #1;
         mem_bus.ack = 1'b0;
         mem_bus.data_out = '0;
         if (mem_bus.cycle && mem_bus.strobe && !slv_hang) begin
            if (slv_cnt >= slv_target) begin
               mem_bus.ack = 1'b1;
               mem_bus.data_out = rd_model(mem_bus.address);
               slv_cnt = 0;
               slv_target = (slv_fixed >= 0) ? slv_fixed : int'($urandom_range(0, 2));
            end else begin
               slv_cnt++;
            end
         end else if (!mem_bus.cycle) begin
            slv_cnt = 0;
         end
      end
   end

   always @(posedge clk) begin
      req_if_s  <= if_bus.cycle;
      req_lsu_s <= lsu_bus.cycle;
   end

   // Monitor: grant-rule model plus scoreboard on routed fields and responses.
   always @(negedge clk) begin
      logic [1:0] exp_g;
      txn_t       t;
      if (!reset) begin
         m_grant  = 2'b00;
         m_streak = 0;
      end else begin
         exp_g = m_grant;
         if (m_grant == 2'b00) begin
            if (req_lsu_s && !(req_if_s && m_streak >= int'(MAX_BURST))) begin
               exp_g = 2'b10;
               if (req_if_s) m_streak = m_streak + 1;
            end else if (req_if_s) begin
               exp_g = 2'b01;
               m_streak = 0;
            end
         end else if ((m_grant == 2'b01 && !req_if_s) || (m_grant == 2'b10 && !req_lsu_s)) begin
            exp_g = 2'b00;
         end
         m_grant = exp_g;
         if (mon_en) begin
            check("grant", 64'(grant), 64'(exp_g));
            check("timeout_idle", 64'(timeout), 64'd0);
            check("if_route_ack", 64'(if_bus.ack), (grant == 2'b01) ? 64'(mem_bus.ack) : 64'd0);
            check("lsu_route_ack", 64'(lsu_bus.ack), (grant == 2'b10) ? 64'(mem_bus.ack) : 64'd0);
            if (grant != 2'b01) check("if_data_blocked", 64'(if_bus.data_out), 64'd0);
            if (grant != 2'b10) check("lsu_data_blocked", 64'(lsu_bus.data_out), 64'd0);
            if (grant == 2'b00) begin
               check("idle_ctrl", 64'({mem_bus.cycle, mem_bus.strobe, mem_bus.write_enable, mem_bus.select}), 64'd0);
               check("idle_addr_data", {mem_bus.address, mem_bus.data_in}, 64'd0);
            end else if ((grant == 2'b01 && if_bus.cycle) || (grant == 2'b10 && lsu_bus.cycle)) begin
               if ((grant == 2'b01 && if_q.size() == 0) || (grant == 2'b10 && lsu_q.size() == 0)) begin
                  check("sb_empty", 64'd0, 64'd1);
               end else begin
                  t = (grant == 2'b01) ? if_q[0] : lsu_q[0];
                  check("mem_ctrl", 64'({mem_bus.cycle, mem_bus.strobe, mem_bus.write_enable, mem_bus.select}),
                        64'({2'b11, t.we, t.sel}));
                  check("mem_addr_data", {mem_bus.address, mem_bus.data_in}, {t.addr, t.wdata});
                  if (grant == 2'b01 && if_bus.ack) begin
                     check("if_rdata", 64'(if_bus.data_out), 64'(t.rdata));
                     void'(if_q.pop_front());
                  end
                  if (grant == 2'b10 && lsu_bus.ack) begin
                     check("lsu_rdata", 64'(lsu_bus.data_out), 64'(t.rdata));
                     void'(lsu_q.pop_front());
                  end
               end
            end
            if (prev_obs == 2'b00 && grant != 2'b00) grant_log.push_back(grant);
         end
      end
      prev_obs = grant;
   end

   initial begin
      logic [1:0] exp_order[10];
      exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      reset = 1'b0;
      slv_hang = 1;
      drive(0, 1'b1, 1'b0, 32'h40, 4'hF, '0);
      drive(1, 1'b1, 1'b0, 32'h80, 4'hF, '0);

      // Reset held with both masters requesting.
      repeat (3) begin
         @(negedge clk);
         check("rst_mem_cyc", 64'(mem_bus.cycle), 64'd0);
         check("rst_grant", 64'(grant), 64'd0);
         check("rst_acks", 64'({if_bus.ack, lsu_bus.ack}), 64'd0);
      end
      #1 reset = 1'b1;
      @(negedge clk);
      check("post_rst_grant", 64'(grant), 64'b10);

      // Async reset mid LSU transaction, slave not acking.
      @(negedge clk);
      check("lsu_hold_cyc", 64'(mem_bus.cycle), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_cyc", 64'(mem_bus.cycle), 64'd0);
      check("async_rst_grant", 64'(grant), 64'd0);
      check("async_rst_ack", 64'(lsu_bus.ack), 64'd0);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk); #1 reset = 1'b1;
      slv_hang = 0;
      @(negedge clk);
      check("rst_release_idle", 64'(grant), 64'd0);

      // Both masters re-requesting back to back: starvation guard order.
      mon_en = 1;
      grant_log.delete();
      fork
         for (int i = 0; i < 8; i++) do_txn(1, 1'b0, 32'h1000 + 32'(i * 4), 4'hF, '0, rd_a);
         for (int i = 0; i < 2; i++) do_txn(0, 1'b0, 32'h2000 + 32'(i * 4), 4'hF, '0, rd_b);
      join
      repeat (2) @(negedge clk);
      check("order_len", 64'(grant_log.size()), 64'd10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++) check("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));

      // IF read with a two-cycle slave wait.
      slv_fixed = 2;
      do_txn(0, 1'b0, 32'h100, 4'hF, '0, rd_a);
      check("if_read_0x100", 64'(rd_a), 64'h1234_5678);
      slv_fixed = -1;

      // LSU byte write while IF waits.
      fork
         do_txn(1, 1'b1, 32'h203, 4'b1000, 32'hAB00_0000, rd_a);
         do_txn(0, 1'b0, 32'h300, 4'hF, '0, rd_b);
      join

      // Randomized contention.
      fork
         rand_master(0, 60);
         rand_master(1, 60);
      join
      repeat (3) @(negedge clk);
      check("if_q_drained", 64'(if_q.size()), 64'd0);
      check("lsu_q_drained", 64'(lsu_q.size()), 64'd0);
      mon_en = 0;

`ifdef WB_ARB_TIMEOUT_EN
      // Hung slave: watchdog aborts the IF transaction.
      begin
         int gcnt;
         bit got;
         gcnt = 0;
         got = 0;
         slv_hang = 1;
         @(negedge clk); #1;
         drive(0, 1'b1, 1'b0, 32'h500, 4'hF, '0);
         for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (grant == 2'b01) gcnt++;
            if (if_bus.ack) got = 1;
         end
         check("wd_fired", 64'(got), 64'd1);
         check("wd_cycle_count", 64'(gcnt), 64'(TO_CYCLES));
         check("wd_data", 64'(if_bus.data_out), 64'hDEAD_BEEF);
         check("wd_pulse", 64'(timeout), 64'd1);
         check("wd_mem_cyc", 64'({mem_bus.cycle, mem_bus.strobe}), 64'd0);
         check("wd_lsu_ack", 64'(lsu_bus.ack), 64'd0);
         @(negedge clk);
         check("wd_idle_next", 64'(grant), 64'd0);
         check("wd_pulse_end", 64'(timeout), 64'd0);
         #1 drive(0, 1'b0, 1'b0, '0, '0, '0);
         slv_hang = 0;
         repeat (2) @(negedge clk);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
